// File: rtl/lbist_pkg.sv
// Shared types and default constants for the LBIST test-pattern generator.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } tpg_state_t;

  // Fibonacci tap masks for the step next = {lfsr[W-2:0], ^(lfsr & POLY)}
  localparam logic [7:0]  POLY_W8  = 8'hB8;
  localparam logic [15:0] POLY_W16 = 16'hB400;
  localparam logic [31:0] POLY_W32 = 32'h8020_0003;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

endpackage

// File: rtl/tpg_lfsr.sv
// Fibonacci LFSR with seed load; a zero seed is replaced by 1 so the register never locks up.
module tpg_lfsr #(
  parameter int                 LFSR_W = 32,
  parameter logic [LFSR_W-1:0]  POLY   = LFSR_W'(32'h8020_0003),
  parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] seed_safe;

  assign seed_safe = (load_val == '0) ? LFSR_W'(1) : load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= seed_safe;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], ^(state & POLY)};
    end
  end

endmodule

// File: rtl/lbist_tpg.sv
// LBIST pattern generator: LFSR-driven scan/PI patterns with a shift/capture session sequencer.
// Define TPG_PHASE_SHIFTER_EN to XOR-decorrelate the chain and PI taps.
//
// state   | meaning
// IDLE    | waiting for start / seed, outputs quiet
// SHIFT   | CHAIN_LEN shift cycles, LFSR advancing, scan_en high
// CAPTURE | one-cycle capture strobe, pattern counted
// DONE    | session complete, holds until start or abort
module lbist_tpg
  import lbist_pkg::*;
#(
  parameter int                LFSR_W     = 32,
  parameter logic [LFSR_W-1:0] POLY       = LFSR_W'(POLY_W32),
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(DEFAULT_SEED),
  parameter int                N_CHAINS   = 7,
  parameter int                PI_W       = 260,
  parameter int                CHAIN_LEN  = 64,
  parameter int                N_PATTERNS = 1024,
  parameter int                CNT_W      = $clog2(N_PATTERNS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                seed_vld,
  input  logic [LFSR_W-1:0]   seed,
  output logic [N_CHAINS-1:0] sc_dout,
  output logic [PI_W-1:0]     pi_dout,
  output logic                scan_en,
  output logic                capture,
  output logic [CNT_W-1:0]    pat_cnt,
  output logic                busy,
  output logic                done
);

  localparam int SH_W = $clog2(CHAIN_LEN + 1);

  tpg_state_t          state, state_nxt;
  logic [SH_W-1:0]     sh_cnt;
  logic [LFSR_W-1:0]   lfsr;
  logic [N_CHAINS-1:0] sc_map;
  logic [PI_W-1:0]     pi_map;
  logic                sh_tc, last_pat;
  logic                lfsr_step, lfsr_load, pi_load, cnt_clr, cnt_inc;

  tpg_lfsr #(
    .LFSR_W (LFSR_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (seed),
    .state    (lfsr)
  );

  assign sh_tc    = (sh_cnt == '0);
  assign last_pat = ((pat_cnt + CNT_W'(1)) == CNT_W'(N_PATTERNS));

  always_comb begin
    state_nxt = state;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    pi_load   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          lfsr_load = seed_vld;
          if (start) begin
            state_nxt = SHIFT;
            cnt_clr   = 1'b1;
          end
        end
        SHIFT: begin
          lfsr_step = 1'b1;
          if (sh_tc) begin
            pi_load   = 1'b1;
            state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          cnt_inc   = 1'b1;
          state_nxt = last_pat ? DONE : SHIFT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Shift timer reloads whenever outside SHIFT, so every pattern starts from a full count
  always_ff @(posedge clk) begin
    if (rst || state != SHIFT) sh_cnt <= SH_W'(CHAIN_LEN - 1);
    else if (!sh_tc)           sh_cnt <= sh_cnt - SH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) pat_cnt <= '0;
    else if (cnt_inc)   pat_cnt <= pat_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)          pi_dout <= '0;
    else if (pi_load) pi_dout <= pi_map;
  end

  for (genvar j = 0; j < N_CHAINS; j++) begin : g_sc
`ifdef TPG_PHASE_SHIFTER_EN
    assign sc_map[j] = lfsr[j] ^ lfsr[(j + LFSR_W / 2) % LFSR_W];
`else
    assign sc_map[j] = lfsr[(j * (LFSR_W / N_CHAINS)) % LFSR_W];
`endif
  end

  for (genvar i = 0; i < PI_W; i++) begin : g_pi
`ifdef TPG_PHASE_SHIFTER_EN
    assign pi_map[i] = lfsr[i % LFSR_W] ^ lfsr[(3 * i + 1) % LFSR_W];
`else
    assign pi_map[i] = lfsr[i % LFSR_W];
`endif
  end

  assign scan_en = (state == SHIFT);
  assign capture = (state == CAPTURE);
  assign busy    = scan_en | capture;
  assign done    = (state == DONE);
  assign sc_dout = scan_en ? sc_map : '0;

endmodule

// File: tb/tb_lbist_tpg.sv
// Scoreboard bench for lbist_tpg in its small plain-tap configuration.
module tb_lbist_tpg;

  localparam int CL = 4;
  localparam int NP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       seed_vld = 1'b0;
  logic [7:0] seed = 8'h00;

  logic [1:0] sc_dout;
  logic [3:0] pi_dout;
  logic       scan_en, capture, busy, done;
  logic [1:0] pat_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lbist_tpg #(
    .LFSR_W     (8),
    .POLY       (8'hB8),
    .SEED       (8'h01),
    .N_CHAINS   (2),
    .PI_W       (4),
    .CHAIN_LEN  (CL),
    .N_PATTERNS (NP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .seed_vld (seed_vld),
    .seed     (seed),
    .sc_dout  (sc_dout),
    .pi_dout  (pi_dout),
    .scan_en  (scan_en),
    .capture  (capture),
    .pat_cnt  (pat_cnt),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_ph = -1 when idle/done, 0..CL-1 shift index, CL for capture
  int         m_ph   = -1;
  logic       m_done = 1'b0;
  logic [1:0] m_cnt  = 2'd0;
  logic [7:0] m_lfsr = 8'h01;
  logic [3:0] m_pi   = 4'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= -1; m_done <= 1'b0; m_cnt <= 2'd0; m_lfsr <= 8'h01; m_pi <= 4'h0;
    end else if (abort) begin
      m_ph <= -1; m_done <= 1'b0; m_cnt <= 2'd0;
    end else if (m_ph < 0) begin
      if (seed_vld) m_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
      if (start) begin
        m_ph <= 0; m_done <= 1'b0; m_cnt <= 2'd0;
      end
    end else if (m_ph < CL) begin
      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      if (m_ph == CL - 1) m_pi <= m_lfsr[3:0];
      m_ph <= m_ph + 1;
    end else begin
      m_cnt <= m_cnt + 2'd1;
      if (int'(m_cnt) + 1 == NP) begin
        m_ph <= -1; m_done <= 1'b1;
      end else begin
        m_ph <= 0;
      end
    end
  end

  typedef struct packed {
    logic [1:0] e_sc;
    logic [3:0] e_pi;
    logic       e_se;
    logic       e_cap;
    logic [1:0] e_cnt;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_lfsr;
  } exp_t;

  exp_t exp_q[$];

  always @(posedge clk) begin
    exp_t r;
    #1;
    r.e_se   = (m_ph >= 0) && (m_ph < CL);
    r.e_cap  = (m_ph == CL);
    r.e_sc   = r.e_se ? {m_lfsr[4], m_lfsr[0]} : 2'b00;
    r.e_pi   = m_pi;
    r.e_cnt  = m_cnt;
    r.e_busy = r.e_se | r.e_cap;
    r.e_done = m_done;
    r.e_lfsr = m_lfsr;
    exp_q.push_back(r);
  end

  always @(negedge clk) begin
    exp_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("sb_sc_dout", 32'(sc_dout), 32'(r.e_sc));
      chk("sb_pi_dout", 32'(pi_dout), 32'(r.e_pi));
      chk("sb_scan_en", 32'(scan_en), 32'(r.e_se));
      chk("sb_capture", 32'(capture), 32'(r.e_cap));
      chk("sb_pat_cnt", 32'(pat_cnt), 32'(r.e_cnt));
      chk("sb_busy",    32'(busy),    32'(r.e_busy));
      chk("sb_done",    32'(done),    32'(r.e_done));
      chk("sb_lfsr",    32'(dut.lfsr), 32'(r.e_lfsr));
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_scan_en"}, 32'(scan_en), 0);
    chk({tag, "_capture"}, 32'(capture), 0);
    chk({tag, "_busy"},    32'(busy),    0);
    chk({tag, "_done"},    32'(done),    0);
    chk({tag, "_pat_cnt"}, 32'(pat_cnt), 0);
    chk({tag, "_sc_dout"}, 32'(sc_dout), 0);
  endtask

  initial begin
    int  k;
    bool_wait: begin end
    // Power-on reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("por");
    chk("por_lfsr", 32'(dut.lfsr), 32'h01);
    chk("por_pi", 32'(pi_dout), 0);

    // Full session: start sampled at edge t
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("sess_se_%0d", c), 32'(scan_en),
          32'((c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 11 && c <= 14)));
      chk($sformatf("sess_cap_%0d", c), 32'(capture), 32'(c == 5 || c == 10 || c == 15));
      chk($sformatf("sess_cnt_%0d", c), 32'(pat_cnt),
          (c <= 5) ? 0 : (c <= 10) ? 1 : (c <= 15) ? 2 : 3);
      chk($sformatf("sess_done_%0d", c), 32'(done), 32'(c == 16));
    end
    chk("sess_busy_end", 32'(busy), 0);

    // Restart from DONE without reseeding, then abort at t+7
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("restart_done", 32'(done), 0);
    chk("restart_cnt", 32'(pat_cnt), 0);
    chk("restart_se", 32'(scan_en), 1);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk_quiet("abort");

    // Zero seed is loaded as 1
    seed_vld = 1'b1; seed = 8'h00;
    @(posedge clk); #1 seed_vld = 1'b0;
    @(negedge clk);
    chk("zero_seed_lfsr", 32'(dut.lfsr), 32'h01);

    // Seed and start together: session begins from the new seed
    seed_vld = 1'b1; seed = 8'h5A; start = 1'b1;
    @(posedge clk); #1 begin seed_vld = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("seed_start_lfsr", 32'(dut.lfsr), 32'h5A);
    chk("seed_start_sc", 32'(sc_dout), 32'h2);
    chk("seed_start_se", 32'(scan_en), 1);

    // start and seed_vld during SHIFT are ignored
    start = 1'b1; seed_vld = 1'b1; seed = 8'hFF;
    repeat (2) @(posedge clk);
    #1 begin start = 1'b0; seed_vld = 1'b0; end
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    chk("ignored_done_cycle", 32'(k), 13);
    chk("ignored_cnt", 32'(pat_cnt), 3);

    // Reset mid-shift behaves like power-on reset
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("midrst");
    chk("midrst_lfsr", 32'(dut.lfsr), 32'h01);
    chk("midrst_pi", 32'(pi_dout), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lbist_tpg.md
# lbist_tpg

Parametrised LBIST test-pattern generator, the next generation of the fixed 7-chain / 260-PI `tpg`. One LFSR drives N scan-chain serial inputs and a parallel primary-input (PI) vector. An internal shift/capture sequencer runs a complete session of N_PATTERNS patterns, with seeding, abort and done handshake. It sits between the LBIST controller (start/seed/abort/done) and the CUT scan wrapper (sc_dout, pi_dout, scan_en, capture).

## Interface
- LFSR_W, 32: LFSR width, ≥ 4.
- POLY, 32'h8020_0003: Fibonacci feedback tap mask, LFSR_W bits.
- SEED, 32'h0000_0001: LFSR value after reset; must be non-zero.
- N_CHAINS, 7: number of scan-chain outputs, 1..LFSR_W.
- PI_W, 260: PI vector width.
- CHAIN_LEN, 64: shift cycles per pattern, ≥ 1.
- N_PATTERNS, 1024: patterns per session, ≥ 1.
- CNT_W, $clog2(N_PATTERNS+1): pattern counter width.

Ports:
- clk  in  1  clock; all logic acts on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  starts a session; honoured only in IDLE or DONE.
- abort  in  1  terminates the session.
- seed_vld  in  1  loads `seed`; honoured only in IDLE or DONE.
- seed  in  LFSR_W  new LFSR seed.
- sc_dout  out  N_CHAINS  scan-in bits to the chains.
- pi_dout  out  PI_W  registered PI pattern.
- scan_en  out  1  high during SHIFT.
- capture  out  1  one-cycle capture strobe.
- pat_cnt  out  CNT_W  number of patterns completed in this session.
- busy  out  1  high in SHIFT or CAPTURE.
- done  out  1  high in DONE.

## Operation
- LFSR step: next = {lfsr[LFSR_W-2:0], ^(lfsr & POLY)}.
  - Advances once per SHIFT cycle only; holds in every other state.
- Seed load: a seed value of 0 is loaded as 1. The LFSR never holds all-zero.
- FSM states and transitions:
  - IDLE → SHIFT on start.
  - SHIFT: runs CHAIN_LEN cycles, then → CAPTURE.
  - CAPTURE: lasts 1 cycle. pat_cnt increments. Then → DONE if the new pat_cnt == N_PATTERNS, else → SHIFT.
  - DONE: holds. On start → SHIFT with pat_cnt cleared; the LFSR continues from its current state unless reseeded.
- sc_dout: combinational tap of the LFSR, gated by scan_en (0 outside SHIFT).
- pi_dout: loaded from the LFSR on the last SHIFT cycle edge of each pattern; holds otherwise.
- Priority order: rst > abort > seed_vld > start.
  - seed_vld and start in the same IDLE/DONE cycle: the seed is loaded and the session starts from the new seed.
  - start or seed_vld in SHIFT or CAPTURE: ignored.
- abort, any state: next state IDLE, pat_cnt = 0, scan_en/capture/done = 0. LFSR and pi_dout retain their values.
- Reset values:
  - FSM = IDLE, lfsr = SEED.
  - sc_dout, pi_dout, scan_en, capture, pat_cnt, busy, done all = 0.
- Reset mid-session behaves identically to power-on reset.

## Timing
- start sampled at edge t:
  - scan_en = 1 during cycles t+1 .. t+CHAIN_LEN.
  - capture = 1 in cycle t+CHAIN_LEN+1.
  - The next SHIFT begins at t+CHAIN_LEN+2.
- Each pattern takes CHAIN_LEN+1 cycles. A full session takes N_PATTERNS·(CHAIN_LEN+1) cycles.
- done rises the cycle after the last capture and stays high until start, abort or rst.
- First-cycle sc_dout is derived from the seed itself (no pre-advance).
- pi_dout is stable for the whole CAPTURE cycle.
- pat_cnt updates on the edge ending CAPTURE.

## Configuration
- TPG_PHASE_SHIFTER_EN defined:
  - sc_dout[j] = lfsr[j] ^ lfsr[(j+LFSR_W/2) % LFSR_W].
  - pi_dout[i] = lfsr[i % LFSR_W] ^ lfsr[(3i+1) % LFSR_W].
  - Purpose: reduces inter-chain correlation.
- Undefined (plain taps):
  - sc_dout[j] = lfsr[(j·(LFSR_W/N_CHAINS)) % LFSR_W].
  - pi_dout[i] = lfsr[i % LFSR_W].
- Timing, FSM and reset behaviour are identical in both modes.

## Structure
- lbist_pkg contains:
  - tpg_state_t enum (IDLE, SHIFT, CAPTURE, DONE).
  - Default POLY constants for widths 8/16/32.
  - DEFAULT_SEED.
- One sub-module, tpg_lfsr:
  - Parameters: LFSR_W, POLY, SEED.
  - Ports: clk, rst, step, load, load_val, state.
  - Contains the zero-seed guard.
- The top level contains the FSM, counters and the output mapping / phase shifter.

## Test plan
Bench parameters: LFSR_W=8, POLY=8'hB8, SEED=8'h01, N_CHAINS=2, PI_W=4, CHAIN_LEN=4, N_PATTERNS=3, plain taps.
- Reset: rst held 2 cycles mid-shift → next cycle IDLE, lfsr=8'h01, all outputs 0.
- Full session: start pulse at t → scan_en high t+1..t+4, capture at t+5/t+10/t+15, pat_cnt 1→2→3, done=1 from t+16, busy=0.
- Zero seed: seed_vld with seed=8'h00 → lfsr=8'h01. seed_vld+start with 8'h5A → sc_dout at t+1 = {lfsr[4],lfsr[0]} of 8'h5A = 2'b10.
- Abort at t+7 (in SHIFT) → IDLE at t+8, pat_cnt=0, scan_en=0, lfsr frozen at its t+7 value.
- Ignored inputs: start and seed_vld=8'hFF asserted during SHIFT → no state change, lfsr sequence unchanged vs golden model.
- Restart from DONE: start without seed → new session continues the LFSR sequence, pat_cnt restarts at 0, done drops at t+1.
